ext_load_sequencer: RTL
=======================

Name: ext_load_sequencer

Overview:
- Host-side transmitter for the accelerator's external write ports: the wr_en_ext_* / wr_addr_ext_* / wr_data_ext_* group on the cpu top level.
- Accepts a 64-bit valid/ready packet stream, decodes a header per packet, and issues single-cycle write strobes. Targets: instruction memory, configuration registers, LUT, sparsity memory, activation memory, FC weights, CNN weights.
- Array targets are assembled from several beats into one N_DIM_ARRAY-lane row.
- A "go" packet pulses the cpu enable input.

Parameters:
- N_DIM_ARRAY, 16, lanes per array row.
- LANE_W, 8, bits per lane. Equals ACT_DATA_WIDTH and WEIGHT_DATA_WIDTH.
- BEATS_PER_ROW, N_DIM_ARRAY*LANE_W/64 (derived), 64-bit beats per row. N_DIM_ARRAY*LANE_W must be a multiple of 64.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat ready
- s_data  in  64  stream beat payload
- wr_en_im, wr_en_conf_reg, wr_en_lut, wr_en_sparsity  out  1 each  64-bit-target write strobes
- wr_en_act_mem, wr_en_fc_w, wr_en_cnn_w  out  1 each  row-target write strobes
- wr_addr_ext  out  32  shared write address for all targets
- wr_data_ext_64  out  64  data for 64-bit targets
- wr_data_ext_row  out  [N_DIM_ARRAY-1:0][LANE_W]  data for row targets
- cpu_enable  out  1  one-cycle start pulse
- busy  out  1  high while not in HDR
- err  out  1  sticky error flag

Behaviour:
- Reset value of every output is 0, with one exception: s_ready is 1 the cycle after reset deasserts.
- Beat transfer rule: a beat transfers when s_valid && s_ready.
- Header format:
  - s_data[3:0] = target: 0 IM, 1 CONF, 2 LUT, 3 SPARSITY, 4 ACT, 5 FC_W, 6 CNN_W, 15 GO.
  - s_data[31:8] = COUNT: writes for 64-bit targets, rows for row targets.
  - s_data[63:32] = base address.
  - Bits [7:4] are ignored.
- FSM states: HDR, PAY, DRAIN, GO.
  - HDR, valid target, COUNT>0 → PAY. Latch target, address, remaining=COUNT, beat_idx=0.
  - HDR, valid target, COUNT=0 → stay in HDR, no writes.
  - HDR, target 15 → GO. COUNT and address are ignored.
  - HDR, target 7..14 → set err. If COUNT>0 → DRAIN with beats=COUNT; else stay in HDR.
  - PAY, 64-bit target: each accepted beat produces one write.
  - PAY, row target: beat b fills lanes b*(64/LANE_W) .. b*(64/LANE_W)+64/LANE_W-1. Lane i of a beat sits at s_data[i*LANE_W +: LANE_W]. The write issues on the beat where b = BEATS_PER_ROW-1.
  - PAY: after each write, address+1 and remaining-1. remaining reaching 0 → HDR.
  - DRAIN: accepts and discards COUNT beats (beats, not rows), then → HDR.
  - GO: s_ready=0 for exactly one cycle, cpu_enable=1 in that cycle, then → HDR.
- Write latency: the strobe, address and data are registered. They are valid in the cycle after the completing beat is accepted.
- Strobes are one-hot and last one cycle; data and address hold until the next write.
- Target latch: the target is captured at the header. Strobes for other targets never assert mid-packet.
- s_ready is high in HDR, PAY and DRAIN. There is no downstream backpressure, because the cpu write ports always accept.
- Wrap-around: the address increments modulo 2^32. remaining is 24 bits; COUNT=0xFFFFFF is legal.
- Stalls: s_valid gaps of any length mid-row keep the partial row and beat_idx.
- Reset mid-packet:
  - FSM returns to HDR and the partial row is discarded.
  - Strobes drop in the reset cycle, cpu_enable drops, and err clears.
  - The next accepted beat is parsed as a header.
- err is cleared only by reset.

Decomposition:
- Shared package (parameters) holds:
  - The target-code enum: TGT_IM..TGT_CNN_W, TGT_GO.
  - Header field offsets.
  - The ld_state_t typedef {HDR, PAY, DRAIN, GO}.
  - BEATS_PER_ROW derivation.
- One sub-module: ext_row_assembler. It holds the beat_idx counter and lane shift/fill register, and emits row_done plus the row. The FSM and address/count logic stay in ext_load_sequencer.

Test Plan:
- IM packet, header {addr=0x10, COUNT=3, tgt=0}, beats A,B,C back-to-back → wr_en_im pulses on 3 consecutive cycles. Addr 0x10, 0x11, 0x12; data A, B, C; each 1 cycle after its beat; busy falls after the third.
- ACT packet, N=16, LANE_W=8, {addr=0x200, COUNT=2, tgt=4}, 4 beats with byte i = lane index + 16*row → wr_en_act_mem pulses twice. Addr 0x200 then 0x201. Lane k of row r = k+16r. No strobe after beats 1 and 3 (odd beats).
- FC_W packet with s_valid low for 5 cycles between beats 1 and 2 → row equals the unstalled case; single wr_en_fc_w pulse.
- Header tgt=9, COUNT=2, then 2 beats, then GO header → err=1, no write strobes. GO takes effect: s_ready=0 and cpu_enable=1 for one cycle, then HDR.
- reset asserted after beat 1 of a CNN_W row → no wr_en_cnn_w. All outputs 0. Next beat tgt=2 COUNT=1 plus payload D → wr_en_lut with data D.
- Header COUNT=0, tgt=1 → no writes, busy stays 0, next beat is treated as a header.

Source files
------------

// File: rtl/ext_load_sequencer_pkg.sv
// rtl/ext_load_sequencer_pkg.sv - shared types and constants for the external load sequencer
package ext_load_sequencer_pkg;

    localparam int BEAT_W          = 64;
    localparam int DEF_N_DIM_ARRAY = 16;
    localparam int DEF_LANE_W      = 8;

    localparam int HDR_TGT_LSB  = 0;
    localparam int HDR_TGT_W    = 4;
    localparam int HDR_CNT_LSB  = 8;
    localparam int HDR_CNT_W    = 24;
    localparam int HDR_ADDR_LSB = 32;
    localparam int HDR_ADDR_W   = 32;

    typedef enum logic [3:0] {
        TGT_IM       = 4'd0,
        TGT_CONF     = 4'd1,
        TGT_LUT      = 4'd2,
        TGT_SPARSITY = 4'd3,
        TGT_ACT      = 4'd4,
        TGT_FC_W     = 4'd5,
        TGT_CNN_W    = 4'd6,
        TGT_GO       = 4'd15
    } tgt_t;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        PAY   = 2'd1,
        DRAIN = 2'd2,
        GO    = 2'd3
    } ld_state_t;

    function automatic int beats_per_row(input int n_dim, input int lane_w);
        return (n_dim * lane_w) / BEAT_W;
    endfunction

    function automatic logic is_row_tgt(input logic [3:0] t);
        return (t == TGT_ACT) || (t == TGT_FC_W) || (t == TGT_CNN_W);
    endfunction

    // Codes 0..6 are real memories; 15 is GO; everything else is a bad header.
    function automatic logic is_data_tgt(input logic [3:0] t);
        return t <= TGT_CNN_W;
    endfunction

endpackage

// File: rtl/ext_row_assembler.sv
// rtl/ext_row_assembler.sv - gathers 64-bit beats into one array row
module ext_row_assembler
    import ext_load_sequencer_pkg::*;
#(
    parameter int N_DIM_ARRAY = DEF_N_DIM_ARRAY,
    parameter int LANE_W      = DEF_LANE_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                beat_valid,
    input  logic [BEAT_W-1:0]                   beat_data,
    output logic                                row_done,
    output logic [N_DIM_ARRAY-1:0][LANE_W-1:0]  row
);

    localparam int ROW_W = N_DIM_ARRAY * LANE_W;
    localparam int BPR   = beats_per_row(N_DIM_ARRAY, LANE_W);
    localparam int IDX_W = (BPR > 1) ? $clog2(BPR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPR - 1);

    logic [IDX_W-1:0] beat_idx;
    logic [ROW_W-1:0] fill_q;
    logic [ROW_W-1:0] fill_d;

    // Beat b lands on lanes b*(64/LANE_W).., which is flat bit offset b*64.
    always_comb begin
        fill_d = fill_q;
        for (int b = 0; b < BPR; b++) begin
            if (beat_valid && (beat_idx == IDX_W'(b))) begin
                fill_d[b*BEAT_W +: BEAT_W] = beat_data;
            end
        end
    end

    assign row_done = beat_valid && (beat_idx == LAST_IDX);
    assign row      = fill_d;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            beat_idx <= '0;
            fill_q   <= '0;
        end else if (beat_valid) begin
            fill_q   <= fill_d;
            beat_idx <= row_done ? '0 : beat_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ext_load_sequencer.sv
// rtl/ext_load_sequencer.sv - packet stream to cpu external write port sequencer
module ext_load_sequencer
    import ext_load_sequencer_pkg::*;
#(
    parameter int N_DIM_ARRAY = DEF_N_DIM_ARRAY,
    parameter int LANE_W      = DEF_LANE_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [63:0]                         s_data,
    output logic                                wr_en_im,
    output logic                                wr_en_conf_reg,
    output logic                                wr_en_lut,
    output logic                                wr_en_sparsity,
    output logic                                wr_en_act_mem,
    output logic                                wr_en_fc_w,
    output logic                                wr_en_cnn_w,
    output logic [31:0]                         wr_addr_ext,
    output logic [63:0]                         wr_data_ext_64,
    output logic [N_DIM_ARRAY-1:0][LANE_W-1:0]  wr_data_ext_row,
    output logic                                cpu_enable,
    output logic                                busy,
    output logic                                err
);

    ld_state_t state, state_d;
    logic [3:0]           tgt_q, tgt_d;
    logic [31:0]          addr_q, addr_d;
    logic [HDR_CNT_W-1:0] rem_q, rem_d;
    logic                 err_q, err_set;
    logic                 wr_fire;
    logic [6:0]           wr_en_q, wr_en_d;
    logic                 beat_fire;
    logic                 row_beat, row_done;
    logic [N_DIM_ARRAY-1:0][LANE_W-1:0] row;

    logic [HDR_TGT_W-1:0]  hdr_tgt;
    logic [HDR_CNT_W-1:0]  hdr_cnt;
    logic [HDR_ADDR_W-1:0] hdr_addr;

    assign hdr_tgt  = s_data[HDR_TGT_LSB  +: HDR_TGT_W];
    assign hdr_cnt  = s_data[HDR_CNT_LSB  +: HDR_CNT_W];
    assign hdr_addr = s_data[HDR_ADDR_LSB +: HDR_ADDR_W];

    // The cpu ports never stall, so the only ready bubble is the GO cycle.
    assign s_ready    = !reset && (state != GO);
    assign beat_fire  = s_valid && s_ready;
    assign busy       = !reset && (state != HDR);
    assign cpu_enable = !reset && (state == GO);
    assign err        = !reset && err_q;

    assign row_beat = beat_fire && (state == PAY) && is_row_tgt(tgt_q);

    ext_row_assembler #(
        .N_DIM_ARRAY (N_DIM_ARRAY),
        .LANE_W      (LANE_W)
    ) u_row_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == HDR),
        .beat_valid (row_beat),
        .beat_data  (s_data),
        .row_done   (row_done),
        .row        (row)
    );

    always_comb begin
        state_d = state;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_set = 1'b0;
        wr_fire = 1'b0;
        case (state)
            HDR: begin
                if (beat_fire) begin
                    if (hdr_tgt == TGT_GO) begin
                        state_d = GO;
                    end else if (is_data_tgt(hdr_tgt)) begin
                        if (hdr_cnt != '0) begin
                            state_d = PAY;
                            tgt_d   = hdr_tgt;
                            addr_d  = hdr_addr;
                            rem_d   = hdr_cnt;
                        end
                    end else begin
                        err_set = 1'b1;
                        if (hdr_cnt != '0) begin
                            state_d = DRAIN;
                            rem_d   = hdr_cnt;
                        end
                    end
                end
            end
            PAY: begin
                if (beat_fire && (!is_row_tgt(tgt_q) || row_done)) begin
                    wr_fire = 1'b1;
                    addr_d  = addr_q + 32'd1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == HDR_CNT_W'(1)) begin
                        state_d = HDR;
                    end
                end
            end
            DRAIN: begin
                if (beat_fire) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == HDR_CNT_W'(1)) begin
                        state_d = HDR;
                    end
                end
            end
            GO:      state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    assign wr_en_d = wr_fire ? (7'd1 << tgt_q) : 7'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= HDR;
            tgt_q           <= '0;
            addr_q          <= '0;
            rem_q           <= '0;
            err_q           <= 1'b0;
            wr_en_q         <= '0;
            wr_addr_ext     <= '0;
            wr_data_ext_64  <= '0;
            wr_data_ext_row <= '0;
        end else begin
            state   <= state_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_q || err_set;
            wr_en_q <= wr_en_d;
            if (wr_fire) begin
                wr_addr_ext <= addr_q;
                if (is_row_tgt(tgt_q)) begin
                    wr_data_ext_row <= row;
                end else begin
                    wr_data_ext_64 <= s_data;
                end
            end
        end
    end

    assign wr_en_im       = !reset && wr_en_q[0];
    assign wr_en_conf_reg = !reset && wr_en_q[1];
    assign wr_en_lut      = !reset && wr_en_q[2];
    assign wr_en_sparsity = !reset && wr_en_q[3];
    assign wr_en_act_mem  = !reset && wr_en_q[4];
    assign wr_en_fc_w     = !reset && wr_en_q[5];
    assign wr_en_cnn_w    = !reset && wr_en_q[6];

endmodule
